// File: rtl/seven_seg_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the seven-segment scan controller.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low g..a patterns, packed so that HEX_SEG[n] is the pattern for nibble n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seven_seg_hex_decoder.sv
`timescale 1ns/1ps
// Combinational hex nibble to active-low seven-segment pattern lookup.
module seven_seg_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
`timescale 1ns/1ps
// Multiplexed scan controller for a common-anode seven-segment display,
// with a double-buffered frame loaded over a valid/ready handshake.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           enable,
  input  logic                                           load_valid,
  output logic                                           load_ready,
  input  logic [4*NUM_DIGITS-1:0]                        load_data,
  input  logic [NUM_DIGITS-1:0]                          load_dp,
  output logic [NUM_DIGITS-1:0]                          anode_n,
  output logic [7:0]                                     segment,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
  output logic                                           frame_done
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]      LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0   = NUM_DIGITS'(1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [4*NUM_DIGITS-1:0] active_data;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_valid;
  logic [3:0]              cur_nibble;
  logic [6:0]              cur_seg;

  assign load_ready = ~pend_valid;
  assign cur_nibble = active_data[{digit_idx, 2'b00} +: 4];

  seven_seg_hex_decoder u_decoder (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Outputs are loaded together with the state transition so the pins always
  // match the phase; active only changes at frame boundaries, which are blanked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      digit_idx   <= '0;
      active_data <= '0;
      active_dp   <= '0;
      pend_data   <= '0;
      pend_dp     <= '0;
      pend_valid  <= 1'b0;
      anode_n     <= '1;
      segment     <= SEG_BLANK;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load_valid && !pend_valid) begin
        pend_data  <= load_data;
        pend_dp    <= load_dp;
        pend_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          anode_n   <= '1;
          segment   <= SEG_BLANK;
          digit_idx <= '0;
          cnt       <= '0;
          if (enable) begin
            state <= BLANK;
            if (pend_valid) begin
              active_data <= pend_data;
              active_dp   <= pend_dp;
              pend_valid  <= 1'b0;
            end
          end
        end
        BLANK: begin
          if (!enable) begin
            state     <= IDLE;
            cnt       <= '0;
            digit_idx <= '0;
            anode_n   <= '1;
            segment   <= SEG_BLANK;
          end else if (cnt == BLANK_LAST) begin
            state   <= SHOW;
            cnt     <= '0;
            anode_n <= ~(ONE_HOT0 << digit_idx);
            segment <= {~active_dp[digit_idx], cur_seg};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          if (!enable) begin
            state     <= IDLE;
            cnt       <= '0;
            digit_idx <= '0;
            anode_n   <= '1;
            segment   <= SEG_BLANK;
          end else if (cnt == SHOW_LAST) begin
            state   <= BLANK;
            cnt     <= '0;
            anode_n <= '1;
            segment <= SEG_BLANK;
            // Wrapping to digit 0 is the frame boundary where a waiting frame goes live.
            if (digit_idx == LAST_DIGIT) begin
              digit_idx  <= '0;
              frame_done <= 1'b1;
              if (pend_valid) begin
                active_data <= pend_data;
                active_dp   <= pend_dp;
                pend_valid  <= 1'b0;
              end
            end else begin
              digit_idx <= digit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for seven_seg_scan_ctrl: a time-based display model predicts
// every cycle's pins and a negedge monitor compares them against the DUT.
module tb_seven_seg_scan_ctrl;

  localparam int N = 4;
  localparam int C = 4;
  localparam int B = 2;
  localparam int S = B + C;
  localparam int P = N * S;

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic       fd;
    logic       rdy;
    logic [1:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [3:0]  load_dp = '0;
  logic [3:0]  anode_n;
  logic [7:0]  segment;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // Model state: whether scanning, cycles since scan start, and the two buffers.
  logic        m_run = 1'b0;
  int          m_t = 0;
  logic [15:0] m_act_data = '0;
  logic [3:0]  m_act_dp = '0;
  logic [15:0] m_pend_data = '0;
  logic [3:0]  m_pend_dp = '0;
  logic        m_pend_v = 1'b0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .CLK_DIV      (C),
    .BLANK_CYCLES (B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .anode_n    (anode_n),
    .segment    (segment),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: position in the frame is derived from elapsed cycles.
  initial begin
    logic acc;
    int   pos;
    int   slot;
    int   nib;
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 1'b0;
        m_t = 0;
        m_act_data = '0;
        m_act_dp = '0;
        m_pend_data = '0;
        m_pend_dp = '0;
        m_pend_v = 1'b0;
        exp_q.delete();
      end else begin
        acc = load_valid && !m_pend_v;
        if (m_run) begin
          if (!enable) m_run = 1'b0;
          else m_t++;
        end else if (enable) begin
          m_run = 1'b1;
          m_t = 0;
        end
        if (m_run && (m_t % P == 0) && m_pend_v) begin
          m_act_data = m_pend_data;
          m_act_dp = m_pend_dp;
          m_pend_v = 1'b0;
        end
        if (acc) begin
          m_pend_data = load_data;
          m_pend_dp = load_dp;
          m_pend_v = 1'b1;
        end
        e.an = 4'hF;
        e.seg = 8'hFF;
        e.fd = 1'b0;
        e.idx = 2'd0;
        if (m_run) begin
          pos = m_t % P;
          slot = pos / S;
          e.idx = 2'(slot);
          e.fd = (m_t > 0) && (pos == 0);
          if ((pos % S) >= B) begin
            e.an = ~(4'b0001 << slot);
            nib = int'((m_act_data >> (4 * slot)) & 16'h000F);
            e.seg = {~m_act_dp[slot], HEX[nib]};
          end
        end
        e.rdy = !m_pend_v;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: one expected entry per clock, compared away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (anode_n !== e.an || segment !== e.seg || frame_done !== e.fd ||
            load_ready !== e.rdy || digit_idx !== e.idx) begin
          errors++;
          $display("[TB] FAIL scan @%0t got an=%b seg=%h fd=%b rdy=%b idx=%0d exp an=%b seg=%h fd=%b rdy=%b idx=%0d",
                   $time, anode_n, segment, frame_done, load_ready, digit_idx,
                   e.an, e.seg, e.fd, e.rdy, e.idx);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] dp);
    int budget;
    @(negedge clk);
    load_valid = 1'b1;
    load_data = d;
    load_dp = dp;
    budget = 0;
    while (!load_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!load_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL load_timeout got ready=%b exp ready=1 within 200 cycles", load_ready);
    end else begin
      @(negedge clk);
    end
    load_valid = 1'b0;
  endtask

  task automatic check_output(input string name);
    checks++;
    if (anode_n !== 4'hF || segment !== 8'hFF || frame_done !== 1'b0 ||
        digit_idx !== 2'd0 || load_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s got an=%b seg=%h fd=%b idx=%0d rdy=%b exp an=1111 seg=ff fd=0 idx=0 rdy=1",
               name, anode_n, segment, frame_done, digit_idx, load_ready);
    end
  endtask

  task automatic wait_for_digit(input logic [1:0] d, input string name);
    int budget;
    budget = 0;
    while (!(digit_idx == d && anode_n == ~(4'b0001 << d)) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s got an=%b idx=%0d exp digit %0d lit within 200 cycles",
               name, anode_n, digit_idx, d);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got timeout exp finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Held in reset, then released with scanning disabled.
    wait_cycles(3);
    check_output("reset_state");
    rst_n = 1'b1;
    wait_cycles(10);

    // First frame, then enable scanning.
    apply_stimulus(16'h4321, 4'b0100);
    @(negedge clk);
    enable = 1'b1;
    wait_cycles(30);

    // Mid-frame load followed by a second load held off until the swap.
    apply_stimulus(16'hFEDC, 4'($urandom));
    apply_stimulus(16'($urandom), 4'($urandom));
    wait_cycles(3 * P);

    // Drop enable while digit 2 is lit, then restart.
    wait_for_digit(2'd2, "find_digit2");
    enable = 1'b0;
    wait_cycles(4);
    enable = 1'b1;
    wait_cycles(P + 5);

    // Randomized mix of loads, enable glitches and idle stretches.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: apply_stimulus(16'($urandom), 4'($urandom));
        1: begin
          @(negedge clk);
          enable = 1'b0;
          wait_cycles($urandom_range(1, 3));
          enable = 1'b1;
        end
        default: wait_cycles($urandom_range(1, 30));
      endcase
    end
    wait_cycles(P);

    // Asynchronous reset while a digit is lit.
    wait_for_digit(2'($urandom_range(0, 3)), "find_lit_digit");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(P + 6);

    enable = 1'b0;
    wait_cycles(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
